// File: rtl/ps2_mouse_rx_pkg.sv
// rtl/ps2_mouse_rx_pkg.sv - shared types, screen limits and clamp helper for the PS/2 mouse receiver
// Contents: HOR_MAX/VER_MAX screen limits, frame/packet state enums,
//           9-bit signed delta type, 14-bit position sum type, clamp_pos().
package mouse_pkg;

   localparam int HOR_MAX = 799;
   localparam int VER_MAX = 599;

   typedef enum logic {IDLE, SHIFT} frame_state_t;
   typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2} pkt_state_t;

   typedef logic signed [8:0]  delta_t;
   typedef logic signed [13:0] pos_sum_t;

   // Saturate a signed position sum into 0..max_v.
   function automatic logic [11:0] clamp_pos(input pos_sum_t v, input int max_v);
      if (v[13])
         return 12'd0;
      else if (v > pos_sum_t'(max_v))
         return 12'(max_v);
      else
         return v[11:0];
   endfunction

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// rtl/ps2_mouse_rx_if.sv - pad-side PS/2 lines and decoded mouse state bundle
// Signals: ps2_clk/ps2_data (raw pad inputs), mouse_xpos/mouse_ypos (12-bit
//          absolute position), mouse_left/mouse_right (button levels),
//          packet_valid (one-cycle update pulse).
// master: the receiver (consumes pad lines, drives mouse state).
// slave : the consumer / pad driver.
interface ps2_mouse_rx_if;

   logic        ps2_clk;
   logic        ps2_data;
   logic [11:0] mouse_xpos;
   logic [11:0] mouse_ypos;
   logic        mouse_left;
   logic        mouse_right;
   logic        packet_valid;

   modport master (
      input  ps2_clk, ps2_data,
      output mouse_xpos, mouse_ypos, mouse_left, mouse_right, packet_valid
   );

   modport slave (
      output ps2_clk, ps2_data,
      input  mouse_xpos, mouse_ypos, mouse_left, mouse_right, packet_valid
   );

endinterface

// File: rtl/ps2_mouse_rx_frame.sv
// rtl/ps2_mouse_rx_frame.sv - PS/2 line sync, falling-edge detect, 11-bit frame FSM with timeout
// Ports: clk, rst (sync active-high); ps2_clk, ps2_data (async pad);
//        rx_byte[7:0] (last received byte), byte_ok (good frame pulse),
//        byte_err (parity/stop error or timeout pulse).
module ps2_frame_rx
   import mouse_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_ok,
   output logic       byte_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_dly_q, clk_dly_d;
   logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   frame_state_t state_q, state_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [8:0]    shift_q, shift_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    byte_q, byte_d;
   logic          ok_q, ok_d, err_q, err_d;
   logic          fall;
   logic [9:0]    frame;

   always_comb begin
      clk_s1_d  = ps2_clk;
      clk_s2_d  = clk_s1_q;
      clk_dly_d = clk_s2_q;
      dat_s1_d  = ps2_data;
      dat_s2_d  = dat_s1_q;

      fall  = clk_dly_q & ~clk_s2_q;
      // Bits enter at the MSB, so after the 10th bit frame[0] is data bit 0,
      // frame[8] is parity and frame[9] is the stop bit.
      frame = {dat_s2_q, shift_q};

      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      timer_d   = timer_q;
      byte_d    = byte_q;
      ok_d      = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (fall && !dat_s2_q) begin
               state_d   = SHIFT;
               bit_cnt_d = 4'd0;
            end
         end
         SHIFT: begin
            // Timeout wins over a coincident fall.
            if (timer_q == TW'(TIMEOUT_CYCLES)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (fall) begin
               timer_d   = '0;
               shift_d   = frame[9:1];
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd9) begin
                  state_d = IDLE;
                  byte_d  = frame[7:0];
                  if ((^frame[8:0]) && frame[9])
                     ok_d = 1'b1;
                  else
                     err_d = 1'b1;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // Sync chain resets to the idle-high line level so no false fall.
         clk_s1_q  <= 1'b1;
         clk_s2_q  <= 1'b1;
         clk_dly_q <= 1'b1;
         dat_s1_q  <= 1'b1;
         dat_s2_q  <= 1'b1;
         state_q   <= IDLE;
         bit_cnt_q <= 4'd0;
         shift_q   <= '0;
         timer_q   <= '0;
         byte_q    <= 8'd0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         clk_s1_q  <= clk_s1_d;
         clk_s2_q  <= clk_s2_d;
         clk_dly_q <= clk_dly_d;
         dat_s1_q  <= dat_s1_d;
         dat_s2_q  <= dat_s2_d;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         timer_q   <= timer_d;
         byte_q    <= byte_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
      end
   end

   assign rx_byte  = byte_q;
   assign byte_ok  = ok_q;
   assign byte_err = err_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// rtl/ps2_mouse_rx.sv - PS/2 mouse packet decoder and clamped absolute position accumulator
// Ports: clk, rst (sync active-high); bus (ps2_mouse_rx_if.master): raw
//        ps2_clk/ps2_data in; mouse_xpos, mouse_ypos, mouse_left,
//        mouse_right, packet_valid out (all registered).
module ps2_mouse_rx
   import mouse_pkg::*;
#(
   parameter int X_MAX          = HOR_MAX,
   parameter int Y_MAX          = VER_MAX,
   parameter int TIMEOUT_CYCLES = 4000
) (
   input  logic          clk,
   input  logic          rst,
   ps2_mouse_rx_if.master bus
);

   logic [7:0] rx_byte;
   logic       byte_ok;
   logic       byte_err;

   ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (bus.ps2_clk),
      .ps2_data (bus.ps2_data),
      .rx_byte  (rx_byte),
      .byte_ok  (byte_ok),
      .byte_err (byte_err)
   );

   pkt_state_t  pkt_q, pkt_d;
   // status: [0] left, [1] right, [2] X sign, [3] Y sign, [4] X ovf, [5] Y ovf
   logic [5:0]  status_q, status_d;
   logic [7:0]  xmag_q, xmag_d;
   logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
   logic        left_q, left_d, right_q, right_d, valid_q, valid_d;
   delta_t      dx, dy;
   pos_sum_t    sum_x, sum_y;

   always_comb begin
      // The Y magnitude is taken straight from the receiver so the update
      // lands in the same cycle byte 2 is accepted.
      dx    = delta_t'({status_q[2], xmag_q});
      dy    = delta_t'({status_q[3], rx_byte});
      sum_x = pos_sum_t'({2'b00, xpos_q}) + pos_sum_t'(dx);
      // PS/2 Y is up-positive, screen Y grows downward.
      sum_y = pos_sum_t'({2'b00, ypos_q}) - pos_sum_t'(dy);

      pkt_d    = pkt_q;
      status_d = status_q;
      xmag_d   = xmag_q;
      xpos_d   = xpos_q;
      ypos_d   = ypos_q;
      left_d   = left_q;
      right_d  = right_q;
      valid_d  = 1'b0;

      if (byte_err) begin
         pkt_d = BYTE0;
      end else if (byte_ok) begin
         case (pkt_q)
            BYTE0: begin
               // Bit 3 is always set in a status byte; anything else is a
               // misaligned byte and is skipped to regain packet sync.
               if (rx_byte[3]) begin
                  status_d = {rx_byte[7:4], rx_byte[1:0]};
                  pkt_d    = BYTE1;
               end
            end
            BYTE1: begin
               xmag_d = rx_byte;
               pkt_d  = BYTE2;
            end
            BYTE2: begin
               pkt_d   = BYTE0;
               valid_d = 1'b1;
               left_d  = status_q[0];
               right_d = status_q[1];
               if (!status_q[4])
                  xpos_d = clamp_pos(sum_x, X_MAX);
               if (!status_q[5])
                  ypos_d = clamp_pos(sum_y, Y_MAX);
            end
            default: pkt_d = BYTE0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_q    <= BYTE0;
         status_q <= 6'd0;
         xmag_q   <= 8'd0;
         xpos_q   <= 12'd0;
         ypos_q   <= 12'd0;
         left_q   <= 1'b0;
         right_q  <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         pkt_q    <= pkt_d;
         status_q <= status_d;
         xmag_q   <= xmag_d;
         xpos_q   <= xpos_d;
         ypos_q   <= ypos_d;
         left_q   <= left_d;
         right_q  <= right_d;
         valid_q  <= valid_d;
      end
   end

   assign bus.mouse_xpos   = xpos_q;
   assign bus.mouse_ypos   = ypos_q;
   assign bus.mouse_left   = left_q;
   assign bus.mouse_right  = right_q;
   assign bus.packet_valid = valid_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// tb/tb_ps2_mouse_rx.sv - directed scoreboard bench for ps2_mouse_rx
module tb_ps2_mouse_rx;

   typedef struct {
      int x;
      int y;
      int l;
      int r;
   } exp_t;

   logic clk;
   logic rst;
   ps2_mouse_rx_if bus ();

   ps2_mouse_rx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   compared   = 0;
   int   mismatched = 0;
   int   pulses     = 0;
   int   exp_pulses = 0;
   exp_t sb[$];
   int   mx = 0, my = 0, ml = 0, mr = 0;

   task automatic check(input string tag, input int got, input int exp);
      compared++;
      assert (got === exp)
      else begin
         mismatched++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.packet_valid === 1'b1) begin
         exp_t e;
         pulses++;
         compared++;
         assert (sb.size() > 0)
         else begin
            mismatched++;
            $error("FAIL unexpected_pulse: got pulse expected none x=%0d", bus.mouse_xpos);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("xpos",  int'(bus.mouse_xpos),  e.x);
            check("ypos",  int'(bus.mouse_ypos),  e.y);
            check("left",  int'(bus.mouse_left),  e.l);
            check("right", int'(bus.mouse_right), e.r);
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends the first nbits of an 11-bit frame (start, 8 data LSB first, odd parity, stop).
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data = f[i];
         wait_clks(10);
         bus.ps2_clk = 1'b0;
         wait_clks(20);
         bus.ps2_clk = 1'b1;
         wait_clks(10);
      end
      bus.ps2_data = 1'b1;
      wait_clks(10);
   endtask

   function automatic int clampi(input int v, input int mx_v);
      if (v < 0) return 0;
      if (v > mx_v) return mx_v;
      return v;
   endfunction

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      exp_t e;
      int dx, dy;
      dx = b0[4] ? int'(b1) - 256 : int'(b1);
      dy = b0[5] ? int'(b2) - 256 : int'(b2);
      if (!b0[6]) mx = clampi(mx + dx, 799);
      if (!b0[7]) my = clampi(my - dy, 599);
      ml = int'(b0[0]);
      mr = int'(b0[1]);
      e.x = mx; e.y = my; e.l = ml; e.r = mr;
      sb.push_back(e);
      exp_pulses++;
      send_frame(b0, 1'b0, 11);
      send_frame(b1, 1'b0, 11);
      send_frame(b2, 1'b0, 11);
   endtask

   initial begin
      rst          = 1'b1;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      wait_clks(4);
      rst = 1'b0;
      wait_clks(2);
      check("rst_xpos",  int'(bus.mouse_xpos),   0);
      check("rst_ypos",  int'(bus.mouse_ypos),   0);
      check("rst_left",  int'(bus.mouse_left),   0);
      check("rst_right", int'(bus.mouse_right),  0);
      check("rst_valid", int'(bus.packet_valid), 0);

      // Basic movement and Y clamp at 0, then down and left moves.
      send_pkt(8'h08, 8'h0A, 8'h05);
      send_pkt(8'h28, 8'h00, 8'hF6);
      send_pkt(8'h19, 8'hF6, 8'h00);

      // Walk to x = 790, clamp at X_MAX, then X overflow holds x.
      send_pkt(8'h08, 8'hFF, 8'h00);
      send_pkt(8'h08, 8'hFF, 8'h00);
      send_pkt(8'h08, 8'hFF, 8'h00);
      send_pkt(8'h08, 8'h19, 8'h00);
      send_pkt(8'h08, 8'h64, 8'h00);
      send_pkt(8'h48, 8'h7F, 8'h00);

      // Parity error in byte 1 aborts the packet.
      send_frame(8'h08, 1'b0, 11);
      send_frame(8'h01, 1'b1, 11);
      send_pkt(8'h0A, 8'h01, 8'h01);

      // Stray non-status byte is skipped.
      send_frame(8'h05, 1'b0, 11);
      send_pkt(8'h08, 8'h02, 8'h00);

      // Partial frame times out; packet must realign.
      send_frame(8'h09, 1'b0, 4);
      wait_clks(4200);
      send_pkt(8'h09, 8'h03, 8'h00);
      send_frame(8'h08, 1'b0, 11);
      send_frame(8'h7E, 1'b0, 4);
      wait_clks(4200);
      send_pkt(8'h08, 8'h01, 8'h01);

      wait_clks(20);
      check("pre_rst_xpos", int'(bus.mouse_xpos), mx);

      // Reset mid-packet clears outputs and partial state.
      send_frame(8'h08, 1'b0, 11);
      send_frame(8'h05, 1'b0, 11);
      rst = 1'b1;
      wait_clks(1);
      check("midrst_xpos",  int'(bus.mouse_xpos),   0);
      check("midrst_ypos",  int'(bus.mouse_ypos),   0);
      check("midrst_left",  int'(bus.mouse_left),   0);
      check("midrst_right", int'(bus.mouse_right),  0);
      check("midrst_valid", int'(bus.packet_valid), 0);
      rst = 1'b0;
      mx = 0; my = 0; ml = 0; mr = 0;
      wait_clks(5);
      send_pkt(8'h08, 8'h03, 8'h00);

      for (int i = 0; i < 200 && sb.size() != 0; i++) wait_clks(1);
      wait_clks(20);
      check("pulse_count",  pulses, exp_pulses);
      check("sb_remaining", sb.size(), 0);
      check("final_xpos",   int'(bus.mouse_xpos), 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
